// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline types: float words, vec4 lane indices and the
// vertex feeder state encoding.
package gfx_pkg;

  typedef logic [31:0] float_t;

  localparam float_t FLOAT_ONE = 32'h3f800000;

  localparam int POS_X = 3;
  localparam int POS_Y = 2;
  localparam int POS_Z = 1;
  localparam int POS_W = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/valid_delay.sv
// Fixed-depth valid shift register; valid_o is valid_i delayed by DEPTH cycles.
module valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= (pipe_q << 1) | DEPTH'(valid_i);
    end
  end

  assign valid_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vertex_feeder.sv
// Reads N xyz vertices from BRAM, appends w=1.0 and strobes them into the
// transformation unit, bounding vertices in flight by counting its returns.
module vertex_feeder
  import gfx_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int MEM_LATENCY  = 2,
  parameter int ISSUE_GAP    = 1,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH:0]   num_vertices_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  mem_rd_out,
  input  logic [95:0]           mem_data_in,
  output float_t                pos [3:0],
  output logic                  valid_out,
  input  logic                  result_valid_in,
  output logic                  busy_out,
  output logic                  done_out,
  output feeder_state_t         state_out
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [CW-1:0] MAX_COUNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [GW-1:0] GAP_RELOAD = GW'(ISSUE_GAP - 1);
  localparam logic [IW-1:0] INF_MAX    = IW'(MAX_INFLIGHT);

  // Handshake: valid_out is a one-cycle strobe with no backpressure; the only
  // flow control is the inflight bound released by result_valid_in returns.

  feeder_state_t         state_q, state_d;
  logic [CW-1:0]         n_q, n_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         returned_q, returned_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q;
  float_t                x_q, y_q, z_q;
  logic                  ret_ok;
  logic                  pipe_out;

  valid_delay #(.DEPTH(MEM_LATENCY)) u_pipe (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .valid_i (rd_q),
    .valid_o (pipe_out)
  );

  always_comb begin
    // Returns with nothing outstanding are stray and must not underflow.
    ret_ok     = result_valid_in && (inflight_q != '0);
    state_d    = state_q;
    n_d        = n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    issued_d   = issued_q + CW'(rd_q);
    returned_d = returned_q + CW'(ret_ok);
    inflight_d = inflight_q + IW'(rd_q) - IW'(ret_ok);
    gap_d      = rd_q ? GAP_RELOAD : ((gap_q != '0) ? gap_q - GW'(1) : '0);
    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          n_d        = (num_vertices_in > MAX_COUNT) ? MAX_COUNT : num_vertices_in;
          issued_d   = '0;
          returned_d = '0;
          gap_d      = '0;
          if (n_d == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_ISSUE;
            busy_d  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (rd_q && (issued_d == n_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((returned_q == n_q) && (inflight_q == '0)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Read strobe is decided one cycle ahead so mem_rd_out is a flop.
    rd_d   = (state_d == ST_ISSUE) && (gap_d == '0) && (issued_d < n_d) &&
             (inflight_d < INF_MAX);
    addr_d = rd_d ? issued_d[ADDR_WIDTH-1:0] : addr_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      inflight_q <= '0;
      gap_q      <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      inflight_q <= inflight_d;
      gap_q      <= gap_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= pipe_out;
      if (pipe_out) begin
        x_q <= mem_data_in[95:64];
        y_q <= mem_data_in[63:32];
        z_q <= mem_data_in[31:0];
      end
    end
  end

  always_comb begin
    pos[POS_X] = x_q;
    pos[POS_Y] = y_q;
    pos[POS_Z] = z_q;
    pos[POS_W] = FLOAT_ONE;
  end

  assign mem_addr_out = addr_q;
  assign mem_rd_out   = rd_q;
  assign valid_out    = valid_q;
  assign busy_out     = busy_q;
  assign done_out     = done_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_vertex_feeder.sv
// Bench for vertex_feeder: two instances (default config, and throttled with
// ISSUE_GAP=3 / MAX_INFLIGHT=2) with BRAM and transformation stub models.
module tb_vertex_feeder;
  import gfx_pkg::*;

  localparam logic [31:0] ONE = 32'h3f800000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          start0, start1;
  logic [10:0]   num0, num1;
  logic [9:0]    addr0, addr1;
  logic          rd0, rd1;
  logic [95:0]   md0, md1, md0_a, md1_a;
  logic [31:0]   pos0 [3:0];
  logic [31:0]   pos1 [3:0];
  logic          val0, val1, ret0, ret1, busy0, busy1, done0, done1;
  feeder_state_t st0, st1;
  logic [31:0]   sr0 = '0;
  logic [31:0]   sr1 = '0;
  int            lat0 = 5;
  int            lat1 = 5;
  logic          stray0 = 1'b0;

  vertex_feeder #(.ADDR_WIDTH(10), .MEM_LATENCY(2), .ISSUE_GAP(1), .MAX_INFLIGHT(16)) dut0 (
    .clk_in(clk), .rst_in(rst), .start_in(start0), .num_vertices_in(num0),
    .mem_addr_out(addr0), .mem_rd_out(rd0), .mem_data_in(md0), .pos(pos0),
    .valid_out(val0), .result_valid_in(ret0), .busy_out(busy0), .done_out(done0),
    .state_out(st0));

  vertex_feeder #(.ADDR_WIDTH(10), .MEM_LATENCY(2), .ISSUE_GAP(3), .MAX_INFLIGHT(2)) dut1 (
    .clk_in(clk), .rst_in(rst), .start_in(start1), .num_vertices_in(num1),
    .mem_addr_out(addr1), .mem_rd_out(rd1), .mem_data_in(md1), .pos(pos1),
    .valid_out(val1), .result_valid_in(ret1), .busy_out(busy1), .done_out(done1),
    .state_out(st1));

  // ---------------- models ----------------
  function automatic logic [31:0] i2f(input int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (v[b]) e = b;
    m = v << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic logic [95:0] mk(input logic [9:0] a);
    return {i2f(int'(a)), i2f(int'(a) + 1), i2f(int'(a) + 2)};
  endfunction

  always @(posedge clk) begin
    md0_a <= mk(addr0);
    md0   <= md0_a;
    md1_a <= mk(addr1);
    md1   <= md1_a;
    sr0   <= {sr0[30:0], val0};
    sr1   <= {sr1[30:0], val1};
  end
  assign ret0 = sr0[lat0-1] | stray0;
  assign ret1 = sr1[lat1-1];

  // ---------------- scoreboard ----------------
  logic [128:0] exp_q[$];
  int passed = 0;
  int total  = 0;
  int rd_cnt[2], val_cnt[2], done_cnt[2], first_val[2], last_val[2];
  int done_cyc[2], last_ret[2], outst[2], max_out[2];
  int rdc[2][4];
  int maxf[2] = '{16, 2};

  task automatic chk(input string name, input logic [128:0] got, input logic [128:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic clr(input int i);
    rd_cnt[i] = 0; val_cnt[i] = 0; done_cnt[i] = 0; first_val[i] = -1;
    last_val[i] = -1; done_cyc[i] = -1; last_ret[i] = -1; outst[i] = 0; max_out[i] = 0;
    for (int j = 0; j < 4; j++) rdc[i][j] = -1;
  endtask

  task automatic mon(input int i, input logic rd, input logic [9:0] addr, input logic v,
                     input logic [127:0] pv, input logic dn, input logic bz, input logic rt);
    logic [128:0] e;
    if (rd) begin
      chk("rd_addr", addr, rd_cnt[i][9:0]);
      if (rd_cnt[i] < 4) rdc[i][rd_cnt[i]] = cyc;
      rd_cnt[i]++;
      outst[i]++;
      if (outst[i] > max_out[i]) max_out[i] = outst[i];
      chk("inflight_bound", outst[i] <= maxf[i], 1);
    end
    if (rt && outst[i] > 0) begin
      outst[i]--;
      last_ret[i] = cyc;
    end
    if (v) begin
      if (val_cnt[i] == 0) first_val[i] = cyc;
      last_val[i] = cyc;
      val_cnt[i]++;
      if (exp_q.size() == 0) chk("pos_unexpected", 0, 1);
      else begin
        e = exp_q.pop_front();
        chk("pos", {i[0], pv}, e);
      end
    end
    if (dn) begin
      done_cnt[i]++;
      done_cyc[i] = cyc;
      chk("busy_at_done", bz, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, rd0, addr0, val0, {pos0[3], pos0[2], pos0[1], pos0[0]}, done0, busy0, ret0);
      mon(1, rd1, addr1, val1, {pos1[3], pos1[2], pos1[1], pos1[0]}, done1, busy1, ret1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start(input int i, input int n, output int k1);
    int cnt;
    cnt = (n > 1024) ? 1024 : n;
    for (int a = 0; a < cnt; a++)
      exp_q.push_back({i[0], i2f(a), i2f(a + 1), i2f(a + 2), ONE});
    @(negedge clk);
    if (i == 0) begin start0 = 1'b1; num0 = n[10:0]; end
    else        begin start1 = 1'b1; num1 = n[10:0]; end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    k1 = cyc;
    if (n > 0) chk("busy_after_start", (i == 0) ? busy0 : busy1, 1);
  endtask

  task automatic wait_done(input int i, input int budget);
    for (int c = 0; c < budget && done_cnt[i] == 0; c++) @(negedge clk);
    chk("done_timeout", done_cnt[i] > 0, 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_reset0();
    chk("rst_addr", addr0, 0);
    chk("rst_rd", rd0, 0);
    chk("rst_valid", val0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pos_xyz", {pos0[3], pos0[2], pos0[1]}, 0);
    chk("rst_pos_w", pos0[0], ONE);
    chk("rst_state", st0, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  int k1;
  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; num0 = '0; num1 = '0;
    clr(0); clr(1);
    repeat (3) @(negedge clk);
    chk_reset0();
    chk("rst_pos_w_b", pos1[0], ONE);
    chk("rst_state_b", st1, ST_IDLE);
    rst = 1'b0;

    // N=4, one vertex per cycle
    lat0 = 5; clr(0);
    start(0, 4, k1);
    wait_done(0, 200);
    for (int j = 0; j < 4; j++) chk("rd_cycle_n4", rdc[0][j], k1 + j);
    chk("rd_cnt_n4", rd_cnt[0], 4);
    chk("val_cnt_n4", val_cnt[0], 4);
    chk("first_val_n4", first_val[0], k1 + 3);
    chk("last_val_n4", last_val[0], k1 + 6);
    chk("done_cnt_n4", done_cnt[0], 1);
    chk("done_after_ret_n4", done_cyc[0] > last_ret[0] && done_cyc[0] <= last_ret[0] + 4, 1);

    // N=0
    clr(0);
    start(0, 0, k1);
    wait_done(0, 50);
    chk("done_cyc_n0", done_cyc[0], k1);
    chk("rd_cnt_n0", rd_cnt[0], 0);
    chk("val_cnt_n0", val_cnt[0], 0);
    chk("done_cnt_n0", done_cnt[0], 1);

    // MAX_INFLIGHT=2 with slow transformation
    lat1 = 20; clr(1);
    start(1, 5, k1);
    wait_done(1, 500);
    chk("rd_cnt_thr", rd_cnt[1], 5);
    chk("val_cnt_thr", val_cnt[1], 5);
    chk("max_out_thr", max_out[1], 2);
    chk("done_cnt_thr", done_cnt[1], 1);
    chk("done_after_ret_thr", done_cyc[1] > last_ret[1] && done_cyc[1] <= last_ret[1] + 4, 1);

    // ISSUE_GAP=3, with a start pulse while busy
    lat1 = 1; clr(1);
    start(1, 3, k1);
    start1 = 1'b1; num1 = 11'd7;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1, 200);
    for (int j = 0; j < 3; j++) chk("rd_cycle_gap", rdc[1][j], k1 + 3 * j);
    chk("rd_cnt_gap", rd_cnt[1], 3);
    chk("val_cnt_gap", val_cnt[1], 3);
    chk("done_cnt_gap", done_cnt[1], 1);

    // Full address range, then over-range count clamps
    clr(0);
    start(0, 1024, k1);
    wait_done(0, 3000);
    chk("rd_cnt_full", rd_cnt[0], 1024);
    chk("val_cnt_full", val_cnt[0], 1024);
    chk("val_span_full", last_val[0] - first_val[0], 1023);
    chk("done_cnt_full", done_cnt[0], 1);
    clr(0);
    start(0, 1025, k1);
    wait_done(0, 3000);
    chk("rd_cnt_clamp", rd_cnt[0], 1024);
    chk("val_cnt_clamp", val_cnt[0], 1024);
    chk("done_cnt_clamp", done_cnt[0], 1);

    // Reset mid-frame, stray returns, then a clean frame
    clr(0);
    start(0, 8, k1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset0();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    clr(0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); stray0 = 1'b1;
      @(negedge clk); stray0 = 1'b0;
    end
    repeat (20) @(negedge clk);
    chk("stray_no_done", done_cnt[0], 0);
    chk("stray_no_valid", val_cnt[0], 0);
    chk("stray_idle", busy0, 0);
    clr(0);
    start(0, 2, k1);
    wait_done(0, 200);
    chk("rd_cnt_post_rst", rd_cnt[0], 2);
    chk("val_cnt_post_rst", val_cnt[0], 2);
    chk("done_cnt_post_rst", done_cnt[0], 1);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
